// File: rtl/bram_16.sv
// Purpose: true dual-port byte RAM that clears itself to zero after reset, then serves two ports.
// Latency: 1 cycle registered read on each port; ready rises after a 2**ADDR_WIDTH-cycle clear sweep.
// Backpressure: none on the ports; accesses are ignored and outputs held at 0 while ready=0.
//
// Ports:
//   clk, rst_n           - single clock, asynchronous active-low reset
//   addra/dina/wea/douta - port A address, write data, write enable, registered read data
//   addrb/dinb/web/doutb - port B address, write data, write enable, registered read data
//   ready                - high once the clear sweep has finished (stays high until reset)
module bram_16 #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  wea,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  input  logic                  web,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_douta;
  logic [DATA_WIDTH-1:0] r_doutb;

  logic w_run;
  logic w_collide;
  logic w_wea;
  logic w_web;

  assign w_run     = (r_state == RUN);
  // Both ports writing one address: port A wins, port B's write is dropped.
  assign w_collide = wea & web & (addra == addrb);
  assign w_wea     = w_run & wea;
  assign w_web     = w_run & web & ~w_collide;

  // State and sweep counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // The counter stops at the last address rather than wrapping, so the final
  // word is cleared exactly once and RUN is entered on that same edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    case (r_state)
      CLEAR: begin
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nxt = RUN;
        end else begin
          w_clr_addr_nxt = r_clr_addr + 1'b1;
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  // Storage array: no reset on the array itself; the sweep provides the zeroing.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_clr_addr] <= '0;
    end else begin
      if (w_wea) r_mem[addra] <= dina;
      if (w_web) r_mem[addrb] <= dinb;
    end
  end

  // Read registers. A port that writes sees its own new data (write-first);
  // a port that only reads sees the array contents before this edge, i.e. the
  // old data when the other port writes the same address. On a collision port B
  // reports port A's data because that is what was stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_douta <= '0;
      r_doutb <= '0;
    end else if (!w_run) begin
      r_douta <= '0;
      r_doutb <= '0;
    end else begin
      r_douta <= wea ? dina : r_mem[addra];
      if (w_collide) begin
        r_doutb <= dina;
      end else begin
        r_doutb <= web ? dinb : r_mem[addrb];
      end
    end
  end

  assign douta = r_douta;
  assign doutb = r_doutb;
  assign ready = w_run;

endmodule

// File: tb/tb_bram_16.sv
// Purpose: self-checking bench for bram_16 using a reference memory and an expected-result queue.
// Latency: expectations are pushed when an access is driven and popped one edge later.
// Backpressure: none; every sweep wait is bounded by a cycle budget.
module tb_bram_16;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int DEPTH = 2 ** AW;
  localparam int SWEEP_BUDGET = 2000;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          wea;
  logic [DW-1:0] douta;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dinb;
  logic          web;
  logic [DW-1:0] doutb;
  logic          ready;

  bram_16 #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addra(addra),
    .dina (dina),
    .wea  (wea),
    .douta(douta),
    .addrb(addrb),
    .dinb (dinb),
    .web  (web),
    .doutb(doutb),
    .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // One access cycle on both ports; the model predicts the outputs after the edge.
  task automatic access(input string tag,
                        input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    exp_t e;
    exp_t g;
    @(negedge clk);
    wea = wa; addra = aa; dina = da;
    web = wb; addrb = ab; dinb = db;
    e.tag = tag;
    e.a   = wa ? da : ref_mem[aa];
    if (wa && wb && (aa == ab)) e.b = da;
    else if (wb)                e.b = db;
    else                        e.b = ref_mem[ab];
    exp_q.push_back(e);
    if (wb) ref_mem[ab] = db;
    if (wa) ref_mem[aa] = da;  // port A overrides port B on the same address
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check({g.tag, "_douta"}, {24'b0, douta}, {24'b0, g.a});
    check({g.tag, "_doutb"}, {24'b0, doutb}, {24'b0, g.b});
    wea = 1'b0; web = 1'b0;
  endtask

  // Count edges from release until ready; outputs must stay 0 throughout.
  task automatic sweep(input string tag, output int cycles);
    logic nonzero;
    nonzero = 1'b0;
    cycles  = 0;
    while (cycles < SWEEP_BUDGET) begin
      @(posedge clk);
      #1;
      cycles++;
      if (douta !== '0 || doutb !== '0) nonzero = 1'b1;
      if (ready === 1'b1) break;
    end
    check({tag, "_ready_cycles"}, cycles, DEPTH);
    check({tag, "_out_zero"}, {31'b0, nonzero}, 0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    wea = 1'b0; addra = '0; dina = '0;
    web = 1'b0; addrb = '0; dinb = '0;
    #12;
    check("rst_ready", {31'b0, ready}, 0);
    check("rst_douta", {24'b0, douta}, 0);
    check("rst_doutb", {24'b0, doutb}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_ready", {31'b0, ready}, 0);

    // First sweep, with write attempts that must be ignored during CLEAR.
    @(negedge clk);
    wea = 1'b1; addra = 10'd2; dina = 8'h77;
    web = 1'b1; addrb = 10'd4; dinb = 8'h99;
    rst_n = 1'b1;
    sweep("sweep1", cyc);
    wea = 1'b0; web = 1'b0;
    model_clear();

    access("clr_rd2_4", 0, 10'd2, 8'h00, 0, 10'd4, 8'h00);
    access("wrA5",      1, 10'd5, 8'h3C, 0, 10'd5, 8'h00);
    access("rdB5_A6",   0, 10'd6, 8'h00, 0, 10'd5, 8'h00);
    access("wrB7",      0, 10'd7, 8'h00, 1, 10'd7, 8'h11);
    access("wA7_rB7",   1, 10'd7, 8'hAA, 0, 10'd7, 8'h00);
    access("rd7",       0, 10'd7, 8'h00, 0, 10'd7, 8'h00);
    access("ww9",       1, 10'd9, 8'h55, 1, 10'd9, 8'h66);
    access("rd9",       0, 10'd9, 8'h00, 0, 10'd9, 8'h00);
    access("wwdiff",    1, 10'd10, 8'hA1, 1, 10'd11, 8'hB2);
    access("rddiff",    0, 10'd11, 8'h00, 0, 10'd10, 8'h00);
    access("wr_edges",  1, 10'd1023, 8'hE7, 1, 10'd0, 8'h5A);
    access("rd_edges",  0, 10'd0, 8'h00, 0, 10'd1023, 8'h00);
    access("rd_last",   0, 10'd1022, 8'h00, 0, 10'd1, 8'h00);

    for (int i = 0; i < 200; i++) begin
      access("rnd",
             1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), DW'($urandom),
             1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), DW'($urandom));
    end

    // Mid-run reset: outputs must drop immediately, not at the next edge.
    access("wr3",  1, 10'd3, 8'hFF, 0, 10'd3, 8'h00);
    access("rd3",  0, 10'd3, 8'h00, 0, 10'd3, 8'h00);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, ready}, 0);
    check("midrst_douta", {24'b0, douta}, 0);
    check("midrst_doutb", {24'b0, doutb}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Interrupt this sweep part-way; the next one must restart from address 0.
    repeat (300) @(posedge clk);
    #1;
    check("partial_ready", {31'b0, ready}, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("partial_rst_ready", {31'b0, ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep("sweep2", cyc);
    model_clear();

    access("post_rd3_5", 0, 10'd3, 8'h00, 0, 10'd5, 8'h00);
    access("post_rd7_9", 0, 10'd7, 8'h00, 0, 10'd9, 8'h00);
    access("post_rd_last", 0, 10'd1023, 8'h00, 0, 10'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_16.md
BRAM_16 -- requirements
Module: bram_16

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: address width; depth = 2**ADDR_WIDTH bytes.
REQ-002 Parameter DATA_WIDTH, default 8: word width of each port (one byte lane).
REQ-003 clk  input  1: single clock for both ports; all state changes on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 addra  input  ADDR_WIDTH: port A address.
REQ-006 dina  input  DATA_WIDTH: port A write data.
REQ-007 wea  input  1: port A write enable.
REQ-008 douta  output  DATA_WIDTH: port A registered read data.
REQ-009 addrb  input  ADDR_WIDTH: port B address.
REQ-010 dinb  input  DATA_WIDTH: port B write data.
REQ-011 web  input  1: port B write enable.
REQ-012 doutb  output  DATA_WIDTH: port B registered read data.
REQ-013 ready  output  1: high when the initial clear sweep is done and the ports accept accesses.

Function
REQ-014 The storage SHALL be a true dual-port array of 2**ADDR_WIDTH words of DATA_WIDTH bits.
REQ-015 Both ports SHALL always be enabled; there are no separate enable inputs.
REQ-016 Reads SHALL take 1 cycle: douta/doutb hold mem[addr] sampled at the previous rising edge.
REQ-017 A write SHALL occur at the rising edge when its port's write enable is 1 and ready=1.
REQ-018 Same-port read-during-write SHALL be write-first: that port's dout shows the new data on the next cycle.
REQ-019 When one port writes address X and the other port reads X in the same cycle, the reader SHALL get the old data (read-first across ports).
REQ-020 When both ports write the same address in the same cycle, port A data SHALL be stored and port B's write discarded.
REQ-021 Both douta and doutb SHALL then read port A's data on the next cycle.
REQ-022 Writes to different addresses in the same cycle SHALL both complete.
REQ-023 FSM states SHALL be CLEAR and RUN.
REQ-024 In CLEAR, an internal counter SHALL write 0 to address 0, 1, ..., 2**ADDR_WIDTH-1, one address per cycle.
REQ-025 In CLEAR, wea/web SHALL be ignored and douta/doutb SHALL be held at 0.
REQ-026 CLEAR -> RUN SHALL occur at the edge that writes the last address; ready rises in the same edge.
REQ-027 RUN SHALL be held until the next reset.
REQ-028 The address counter SHALL NOT wrap: the last address is written exactly once.
REQ-029 Addresses SHALL be full-width binary; no out-of-range case exists.

Reset
REQ-030 While rst_n=0, the block SHALL hold: state=CLEAR, counter=0, ready=0, douta=0, doutb=0.
REQ-031 Asserting rst_n mid-operation SHALL immediately force the REQ-030 values.
REQ-032 On release after a mid-operation reset, the clear sweep SHALL restart from address 0.
REQ-033 After the sweep completes, every memory word SHALL read 0.

Verification
REQ-034 Release rst_n, count cycles -> ready rises exactly 1024 cycles after release (ADDR_WIDTH=10); douta=doutb=0 throughout.
REQ-035 ready=1: write A addr 5 data 0x3C, then read B addr 5 -> doutb=0x3C one cycle after the read address is applied; unwritten addr 6 -> 0x00.
REQ-036 Same cycle: A writes addr 7 data 0xAA, B reads addr 7 (old 0x11) -> doutb=0x11, douta=0xAA.
REQ-037 Next cycle after REQ-036 -> doutb=0xAA.
REQ-038 Same cycle: A writes addr 9 data 0x55, B writes addr 9 data 0x66 -> subsequent reads on both ports = 0x55.
REQ-039 Pulse rst_n low mid-run after writing 0xFF to addr 3 -> ready=0 and outputs 0 immediately; after the new sweep, addr 3 reads 0x00.
REQ-040 During CLEAR, drive wea=1, addra=2, dina=0x77 -> after ready=1, addr 2 reads 0x00.
